// File: rtl/led_fade_driver.sv
// led_fade_driver: PWM LED driver with a linear fade-out trail per channel.
// Ports: CLK/RESET (sync, active-high), EN fade enable, PAT_VLD/PAT_IN pattern
// strobe and 4-bit pattern, LED registered PWM outputs, LEVEL packed per-channel
// brightness, BUSY high while any channel is fading.
module led_fade_driver #(
   parameter int PWM_BITS = 4,
   parameter int STEP_DIV = 4
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     EN,
   input  logic                     PAT_VLD,
   input  logic [3:0]               PAT_IN,
   output logic [3:0]               LED,
   output logic [4*PWM_BITS-1:0]    LEVEL,
   output logic                     BUSY
);

   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PWM_BITS-1:0] MAX = '1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_ON    = 2'd1,
      S_DECAY = 2'd2
   } state_t;

   logic [3:0]          pat_q;
   logic [DIV_W-1:0]    div_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                step;

   state_t              state_q [4];
   state_t              state_d [4];
   logic [PWM_BITS-1:0] level_q [4];
   logic [PWM_BITS-1:0] level_d [4];

   assign step = EN && (div_cnt == DIV_LAST);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pat_q   <= '0;
         div_cnt <= '0;
         pwm_cnt <= '0;
         LED     <= '0;
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= S_OFF;
            level_q[i] <= '0;
         end
      end else begin
         if (PAT_VLD)
            pat_q <= PAT_IN;
         if (EN)
            div_cnt <= step ? '0 : div_cnt + 1'b1;
         pwm_cnt <= pwm_cnt + 1'b1;
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            level_q[i] <= level_d[i];
            // Full level forces a steady 1 despite the counter reaching MAX.
            LED[i] <= (level_q[i] == MAX) || (level_q[i] > pwm_cnt);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         level_d[i] = level_q[i];
         unique case (state_q[i])
            S_OFF: begin
               level_d[i] = '0;
               if (pat_q[i]) begin
                  state_d[i] = S_ON;
                  level_d[i] = MAX;
               end
            end
            S_ON: begin
               level_d[i] = MAX;
               if (!pat_q[i])
                  state_d[i] = S_DECAY;
            end
            S_DECAY: begin
               // Re-trigger wins over any pending decrement.
               if (pat_q[i]) begin
                  state_d[i] = S_ON;
                  level_d[i] = MAX;
               end else if (step) begin
                  level_d[i] = level_q[i] - 1'b1;
                  if (level_q[i] == PWM_BITS'(1))
                     state_d[i] = S_OFF;
               end
            end
            default: begin
               state_d[i] = S_OFF;
               level_d[i] = '0;
            end
         endcase
      end
   end

   always_comb begin
      LEVEL = '0;
      BUSY  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         LEVEL[i*PWM_BITS +: PWM_BITS] = level_q[i];
         if (state_q[i] == S_DECAY)
            BUSY = 1'b1;
      end
   end

endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver: directed scenarios plus random stimulus for
// led_fade_driver, checked each cycle against a behavioural model.
module tb_led_fade_driver;

   localparam int PB  = 4;
   localparam int SD  = 4;
   localparam int MX  = (1 << PB) - 1;
   localparam int PER = 1 << PB;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          EN = 1'b1;
   logic          PAT_VLD = 1'b0;
   logic [3:0]    PAT_IN = '0;
   logic [3:0]    LED;
   logic [4*PB-1:0] LEVEL;
   logic          BUSY;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: integer brightness, "held" flag while the bit is lit,
   // count of enabled cycles for step timing, free-running cycle count for PWM.
   int m_lvl [4];
   bit m_held [4];
   int m_pat;
   int m_en_cycles;
   int m_pwm;
   int m_led;

   led_fade_driver #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .EN      (EN),
      .PAT_VLD (PAT_VLD),
      .PAT_IN  (PAT_IN),
      .LED     (LED),
      .LEVEL   (LEVEL),
      .BUSY    (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_busy();
      for (int i = 0; i < 4; i++)
         if (!m_held[i] && m_lvl[i] > 0) return 1;
      return 0;
   endfunction

   task automatic model_edge();
      int nl;
      bit st;
      if (RESET) begin
         m_pat = 0; m_en_cycles = 0; m_pwm = 0; m_led = 0;
         for (int i = 0; i < 4; i++) begin
            m_lvl[i] = 0; m_held[i] = 0;
         end
         return;
      end
      nl = 0;
      for (int i = 0; i < 4; i++)
         if (m_lvl[i] == MX || m_lvl[i] > m_pwm) nl |= (1 << i);
      st = EN && (m_en_cycles % SD == SD - 1);
      for (int i = 0; i < 4; i++) begin
         if (m_pat[i]) begin
            m_held[i] = 1; m_lvl[i] = MX;
         end else if (m_held[i]) begin
            m_held[i] = 0;
         end else if (st && m_lvl[i] > 0) begin
            m_lvl[i] = m_lvl[i] - 1;
         end
      end
      if (EN) m_en_cycles++;
      m_pwm = (m_pwm + 1) % PER;
      if (PAT_VLD) m_pat = PAT_IN;
      m_led = nl;
   endtask

   task automatic compare();
      for (int i = 0; i < 4; i++)
         chk($sformatf("level%0d", i), int'(LEVEL[i*PB +: PB]), m_lvl[i]);
      chk("led", int'(LED), m_led);
      chk("busy", int'(BUSY), m_busy());
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
      compare();
   endtask

   initial begin
      int hi;
      bit hit;
      // Reset held two cycles with a pattern offered.
      RESET = 1; EN = 1; PAT_VLD = 1; PAT_IN = 4'hF;
      tick(); tick();
      chk("rst_level", int'(LEVEL), 0);
      chk("rst_led", int'(LED), 0);
      RESET = 0;
      tick();
      chk("rel_latch_level", int'(LEVEL), 0);
      tick();
      chk("rel_all_on", int'(LEVEL), 16'hFFFF);
      PAT_VLD = 0;
      RESET = 1; tick(); RESET = 0;

      // Light channel 0.
      PAT_VLD = 1; PAT_IN = 4'b0001; tick();
      PAT_VLD = 0; PAT_IN = 4'h0;
      tick();
      chk("light_l15", int'(LEVEL), 15);
      tick();
      chk("light_led", int'(LED), 1);
      repeat (5) tick();

      // Decay, then freeze at level 8.
      PAT_VLD = 1; PAT_IN = 4'h0; tick(); PAT_VLD = 0;
      tick();
      chk("decay_busy", int'(BUSY), 1);
      hit = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
         tick();
         if (m_lvl[0] == 8) hit = 1;
      end
      chk("reach_l8", int'(hit), 1);
      EN = 0;
      tick();
      hi = 0;
      for (int c = 0; c < 64; c++) begin
         tick();
         hi += int'(LED[0]);
      end
      chk("duty_8of16", hi, 32);
      chk("frozen_l8", int'(LEVEL[3:0]), 8);
      EN = 1;

      // Re-trigger while a step lands at level 5.
      hit = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
         if (m_lvl[0] == 5 && !m_held[0] && (m_en_cycles % SD == SD - 1)) begin
            hit = 1;
         end else begin
            tick();
         end
      end
      chk("reach_l5_step", int'(hit), 1);
      PAT_VLD = 1; PAT_IN = 4'b0001; tick(); PAT_VLD = 0;
      chk("retrig_old_pat", int'(LEVEL[3:0]), 4);
      tick();
      chk("retrig_on", int'(LEVEL[3:0]), 15);
      chk("retrig_busy", int'(BUSY), 0);

      // Let channel 0 fade to off fully.
      PAT_VLD = 1; PAT_IN = 4'h0; tick(); PAT_VLD = 0;
      hit = 0;
      for (int c = 0; c < 120 && !hit; c++) begin
         tick();
         if (m_lvl[0] == 0 && !m_held[0]) hit = 1;
      end
      chk("fade_off", int'(hit), 1);
      tick();
      chk("off_led", int'(LED), 0);
      chk("off_busy", int'(BUSY), 0);

      // Reset during a four-channel decay.
      PAT_VLD = 1; PAT_IN = 4'hF; tick();
      PAT_IN = 4'h0; tick(); PAT_VLD = 0;
      hit = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
         tick();
         if (m_lvl[3] == 9) hit = 1;
      end
      chk("reach_l9", int'(hit), 1);
      RESET = 1; tick(); RESET = 0;
      chk("midrst_level", int'(LEVEL), 0);
      chk("midrst_led", int'(LED), 0);
      chk("midrst_busy", int'(BUSY), 0);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         RESET   = ($urandom % 600) == 0;
         PAT_VLD = ($urandom % 30) == 0;
         PAT_IN  = 4'($urandom);
         EN      = ($urandom % 8) != 0;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
